// File: rtl/median_rank_filter.sv
// Rank-order filter: streams a LENGTH-sample frame into a register window, then bubble-sorts
// one compare-swap per cycle until the selected rank is final. `define MEDIAN_RANK_EN adds a runtime RANK port.
module median_rank_filter #(
   parameter int SIZE   = 8,
   parameter int LENGTH = 9,
   parameter int CW     = $clog2(LENGTH+1)
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [SIZE-1:0]           DI,
   input  logic                      DSI,
`ifdef MEDIAN_RANK_EN
   input  logic [$clog2(LENGTH)-1:0] RANK,
`endif
   output logic [SIZE-1:0]           DO,
   output logic                      DSO,
   output logic                      BUSY,
   output logic                      ERR
);

   localparam int RW = $clog2(LENGTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT} state_t;

   state_t              r_state;
   logic [SIZE-1:0]     r_win [LENGTH];
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       r_pass;
   logic [CW-1:0]       r_step;
   logic [RW-1:0]       r_rank;
   logic [SIZE-1:0]     r_do;
   logic                r_dso;
   logic                r_busy;
   logic                r_err;

   logic [RW-1:0]       w_rank_in;
   logic [CW-1:0]       w_last;
   logic [SIZE-1:0]     w_a;
   logic [SIZE-1:0]     w_b;
   logic                w_swap;
   logic [SIZE-1:0]     w_next [LENGTH];
   logic [SIZE-1:0]     w_sel;
   logic                w_step_end;
   logic                w_done;
   logic                w_load;

`ifdef MEDIAN_RANK_EN
   assign w_rank_in = (RANK > RW'(LENGTH-1)) ? RW'(LENGTH-1) : RANK;
`else
   assign w_rank_in = RW'((LENGTH-1)/2);
`endif

   // Rank 0 becomes final together with rank 1, so its zero-step pass is skipped.
   assign w_last     = (r_rank == '0) ? CW'(LENGTH-2) : (CW'(LENGTH-1) - CW'(r_rank));
   assign w_step_end = (r_step == (CW'(LENGTH-2) - r_pass));
   assign w_done     = w_step_end && (r_pass == w_last);
   assign w_load     = DSI && ((r_state == S_IDLE) || (r_state == S_LOAD));

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < LENGTH-1; k++) begin
         if (r_step == CW'(k)) begin
            w_a = r_win[k];
            w_b = r_win[k+1];
         end
      end
      w_swap = (w_a > w_b);
      for (int k = 0; k < LENGTH; k++) begin
         w_next[k] = r_win[k];
      end
      for (int k = 0; k < LENGTH-1; k++) begin
         if (w_swap && (r_step == CW'(k))) begin
            w_next[k]   = w_b;
            w_next[k+1] = w_a;
         end
      end
      // The result is taken from the post-swap window of the final step.
      w_sel = '0;
      for (int k = 0; k < LENGTH; k++) begin
         if (r_rank == RW'(k)) begin
            w_sel = w_next[k];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < LENGTH; k++) begin
            r_win[k] <= '0;
         end
      end else if (w_load) begin
         for (int k = 0; k < LENGTH-1; k++) begin
            r_win[k] <= r_win[k+1];
         end
         r_win[LENGTH-1] <= DI;
      end else if (r_state == S_SORT) begin
         for (int k = 0; k < LENGTH; k++) begin
            r_win[k] <= w_next[k];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pass  <= '0;
         r_step  <= '0;
         r_rank  <= '0;
         r_do    <= '0;
         r_dso   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_dso <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (DSI) begin
                  r_cnt   <= CW'(1);
                  r_rank  <= w_rank_in;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (DSI) begin
                  if (r_cnt != CW'(LENGTH)) begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end else begin
                  r_cnt  <= '0;
                  r_pass <= '0;
                  r_step <= '0;
                  if (r_cnt == CW'(LENGTH)) begin
                     r_state <= S_SORT;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_SORT: begin
               r_err <= DSI;
               if (w_done) begin
                  r_do    <= w_sel;
                  r_dso   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_step_end) begin
                  r_pass <= r_pass + CW'(1);
                  r_step <= '0;
               end else begin
                  r_step <= r_step + CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign DO   = r_do;
   assign DSO  = r_dso;
   assign BUSY = r_busy;
   assign ERR  = r_err;

endmodule

// File: tb/tb_median_rank_filter.sv
// Directed scoreboard bench for median_rank_filter (LENGTH=9, SIZE=8); rank tests need MEDIAN_RANK_EN.
`timescale 1ns/1ps
module tb_median_rank_filter;

   localparam int SIZE   = 8;
   localparam int LENGTH = 9;

   logic            CLK  = 1'b0;
   logic            nRST = 1'b0;
   logic [SIZE-1:0] DI   = '0;
   logic            DSI  = 1'b0;
`ifdef MEDIAN_RANK_EN
   logic [3:0]      rank = 4'd4;
`endif
   logic [SIZE-1:0] DO;
   logic            DSO;
   logic            BUSY;
   logic            ERR;

   median_rank_filter #(.SIZE(SIZE), .LENGTH(LENGTH)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .DI   (DI),
      .DSI  (DSI),
`ifdef MEDIAN_RANK_EN
      .RANK (rank),
`endif
      .DO   (DO),
      .DSO  (DSO),
      .BUSY (BUSY),
      .ERR  (ERR)
   );

   always #5 CLK = ~CLK;

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int t_fall    = 0;
   int err_seen  = 0;
   int busy_seen = 0;
   int exp_do_q[$];
   int exp_lat_q[$];
   logic [SIZE-1:0] fq[$];
   int m_do;
   int m_lat;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: samples 1ns after each rising edge and scores every DSO.
   always begin
      @(posedge CLK);
      cyc++;
      #1;
      if (ERR) err_seen++;
      if (BUSY) busy_seen++;
      if (DSO) begin
         if (exp_do_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_dso: got DO=%0d, expected no result", DO);
         end else begin
            m_do  = exp_do_q.pop_front();
            m_lat = exp_lat_q.pop_front();
            check("result_DO", int'(DO), m_do);
            check("result_latency", cyc - t_fall, m_lat);
         end
      end
   end

   // Called at a falling edge; returns at the falling edge where DSI drops.
   task automatic send_frame(input bit push, input int e_do, input int e_lat);
      for (int i = 0; i < fq.size(); i++) begin
         DI  = fq[i];
         DSI = 1'b1;
         @(negedge CLK);
      end
      DSI    = 1'b0;
      t_fall = cyc;
      if (push) begin
         exp_do_q.push_back(e_do);
         exp_lat_q.push_back(e_lat);
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_do_q.size() != 0 || BUSY) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check({name, "_in_time"}, int'(n < 200), 1);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      check("rst_DO",   int'(DO),   0);
      check("rst_DSO",  int'(DSO),  0);
      check("rst_BUSY", int'(BUSY), 0);
      check("rst_ERR",  int'(ERR),  0);
      nRST = 1'b1;
      @(negedge CLK);

      err_seen = 0; busy_seen = 0;
      fq = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
      send_frame(1'b1, 5, 31);
      wait_done("median");
      check("median_busy_cycles", busy_seen, 30);
      check("median_err", err_seen, 0);

      fq = '{8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd2, 8'd2, 8'd9, 8'd9};
      send_frame(1'b1, 5, 31);
      wait_done("sliding");

      err_seen = 0;
      fq = '{8'd200, 8'd10, 8'd255, 8'd0, 8'd128, 8'd64, 8'd32, 8'd16, 8'd100};
      send_frame(1'b1, 64, 31);
      repeat (31) @(negedge CLK);
      fq = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      send_frame(1'b1, 50, 31);
      wait_done("back_to_back");
      check("b2b_err", err_seen, 0);

      err_seen = 0;
      fq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      send_frame(1'b0, 0, 0);
      repeat (4) @(negedge CLK);
      check("short_err", err_seen, 1);
      check("short_busy", int'(BUSY), 0);
      fq = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
      send_frame(1'b1, 5, 31);
      wait_done("after_short");

      err_seen = 0; busy_seen = 0;
      fq = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      send_frame(1'b1, 50, 31);
      repeat (10) @(negedge CLK);
      DI  = 8'd255;
      DSI = 1'b1;
      repeat (3) @(negedge CLK);
      DSI = 1'b0;
      wait_done("busy_violation");
      check("busy_violation_err", err_seen, 3);
      check("busy_violation_busy_cycles", busy_seen, 30);

      err_seen = 0;
      fq = '{8'd200, 8'd10, 8'd255, 8'd0, 8'd128, 8'd64, 8'd32, 8'd16, 8'd100};
      send_frame(1'b0, 0, 0);
      repeat (10) @(negedge CLK);
      #2 nRST = 1'b0;
      #1;
      check("midrst_DO",   int'(DO),   0);
      check("midrst_DSO",  int'(DSO),  0);
      check("midrst_BUSY", int'(BUSY), 0);
      @(negedge CLK);
      nRST = 1'b1;
      repeat (40) @(negedge CLK);
      check("midrst_err", err_seen, 0);
      fq = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
      send_frame(1'b1, 5, 31);
      wait_done("after_reset");

`ifdef MEDIAN_RANK_EN
      rank = 4'd0;
      send_frame(1'b1, 1, 37);
      wait_done("rank_min");
      rank = 4'd8;
      send_frame(1'b1, 9, 9);
      rank = 4'd0;
      wait_done("rank_max");
      rank = 4'd15;
      send_frame(1'b1, 9, 9);
      wait_done("rank_clamp");
      rank = 4'd4;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/median_rank_filter.md
Name: median_rank_filter

Overview:
- Parametrised successor of the single-window median block. Captures a frame of LENGTH samples streamed on DI while DSI is high. Returns the RANK-th smallest sample on DO, pulsing DSO for one cycle.
- Selection uses a sequential bubble engine, one compare-swap per cycle, over an internal register window. Sits between the pixel source and downstream filtering stages.
- Adds over the previous generation: any window length, runtime rank selection, busy/error reporting and clean async reset.

Parameters:
- SIZE, 8, sample width in bits.
- LENGTH, 9, samples per frame; legal range ≥2; odd for a true median.
- CW, $clog2(LENGTH+1), internal counter width; derived, not to be overridden.

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  asynchronous reset, active-low.
- DI  in  SIZE  sample data; valid every cycle DSI=1.
- DSI  in  1  frame strobe; high for the frame duration.
- RANK  in  $clog2(LENGTH)  selected rank, 0 = min, LENGTH-1 = max. Present only with MEDIAN_RANK_EN.
- DO  out  SIZE  result; holds last result until the next DSO.
- DSO  out  1  one-cycle result-valid pulse.
- BUSY  out  1  high during SORT.
- ERR  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, window R[0..LENGTH-1]=0, counters=0. Outputs DO=0, DSO=0, BUSY=0, ERR=0. An in-flight frame is discarded, with no DSO or ERR.
- Window load:
  - Each cycle with DSI=1 in IDLE/LOAD: R shifts, R[LENGTH-1] <= DI, R[k] <= R[k+1]; sample count increments, saturating at LENGTH.
  - More than LENGTH samples: only the last LENGTH are kept (sliding window).
- States:
  - IDLE: DSI=1 -> LOAD. The first sample is captured that same cycle and rank is sampled.
  - LOAD: stays while DSI=1. On DSI=0:
    - count==LENGTH -> SORT.
    - count<LENGTH -> IDLE, ERR=1 for one cycle, frame dropped.
  - SORT: BUSY=1.
    - Pass p (p=0,1,..) runs j=0..LENGTH-2-p, one step per cycle. Each step: if R[j] > R[j+1] (unsigned, strict), swap them. Equal values never swap.
    - After pass p, position LENGTH-1-p is final.
    - Terminate when position RANK is final. Passes with zero steps are skipped.
    - Then DO <= R[RANK], DSO=1 for exactly one cycle, -> IDLE with BUSY=0 in that same cycle.
- Latency: from the first cycle with DSI=0 to DSO, Σ_{p=0}^{LENGTH-1-RANK} (LENGTH-1-p) cycles, plus 1.
  - LENGTH=9: RANK=4 -> 31; RANK=8 -> 9; RANK=0 -> 37.
- Rank sampling: RANK is sampled on the IDLE->LOAD transition; later changes have no effect on that frame. A value ≥LENGTH is clamped to LENGTH-1.
- DSI=1 during SORT: sample ignored, window untouched, ERR=1 that cycle. Sorting continues and the result is unaffected.
- DSI rising in the same cycle DSO is issued: the sample is accepted as the first of a new frame (IDLE->LOAD behaviour).
- Back-to-back frames need no idle gap besides SORT. R is not cleared between frames; a full LENGTH-sample load always overwrites it.

Optional Feature:
- MEDIAN_RANK_EN defined: RANK port exists and behaves as above.
- Not defined: RANK port absent; rank fixed at (LENGTH-1)/2 (integer), so latency for LENGTH=9 is always 31. All other behaviour is identical.

Test Plan:
- Median: LENGTH=9, RANK=4, frame 9,3,7,1,8,2,6,5,4 -> DSO single pulse 31 cycles after DSI falls, DO=5, BUSY high 30 cycles, ERR never.
- Extremes: same frame with RANK=0 -> DO=1 after 37 cycles; RANK=8 -> DO=9 after 9 cycles.
- Duplicates and sliding window: 11 samples 0,0,5,5,5,5,5,2,2,9,9 with RANK=4 -> window is the last 9 samples 5,5,5,5,5,2,2,9,9, DO=5.
- Short frame: DSI high for 5 samples then low -> ERR one-cycle pulse, no DSO, state IDLE; a following full frame is processed normally.
- Busy violation: assert DSI for 3 cycles mid-SORT -> ERR pulses 3 cycles, DO/latency identical to the clean run.
- Reset mid-operation: nRST low asynchronously during SORT -> DO=0, DSO=0, BUSY=0 immediately. After release, a new frame gives a correct result.
